mem_req_arbiter: RTL

- Sits directly upstream of the memory controller: the controller drives the RAM, and this block drives the controller's request port.
- Accepts requests from two Beta-side ports:
  - instruction fetch, read-only
  - data port, load/store
- Arbitrates between them round-robin and runs the controller's Valid/Ready handshake for the granted port.
- Returns read data and a one-cycle ack to the requester, with a timeout guard on a stalled controller.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_arb_rr.sv | 38 +++
 rtl/mem_req_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory request arbiter: FSM encoding,
// read/write polarity and grant identifiers.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam logic RW_READ     = 1'b1;
  localparam logic RW_WRITE    = 1'b0;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant between the fetch and data ports.
// When both ports request, the port that did not win last time is chosen.
// last_grant only advances when grant_en is high and some port requests,
// so it always names the port owning the transaction in flight.
module mem_arb_rr
  import mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic grant_en,
  input  logic if_req,
  input  logic d_req,
  output logic grant_valid,
  output logic grant,
  output logic last_grant
);

  // Pick a winner from the current requests and the previous winner.
  always_comb begin
    grant_valid = if_req | d_req;
    grant       = GRANT_FETCH;
    if (if_req && d_req) begin
      grant = ~last_grant;
    end else if (d_req) begin
      grant = GRANT_DATA;
    end
  end

  // Remember the winner whenever a grant is actually taken.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= GRANT_FETCH;
    end else if (grant_en && grant_valid) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Front end of the memory controller: arbitrates fetch and data requests,
// runs the controller's valid/ready handshake, returns data with a one-cycle
// ack, and aborts with err if the controller stalls a phase too long.
//
// Handshake with the controller: mc_valid is high in ISSUE and WAIT only.
// mc_ready high in IDLE means the controller can take a request; its fall
// while mc_valid is high is the accept, and its rise afterwards is the
// completion (read data is on mc_data at that edge). Request fields and
// the bus stay stable from issue until completion or timeout.
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic              if_ack,
  output logic [DWIDTH-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_ack,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              mc_valid,
  output logic              mc_rw,
  output logic [AWIDTH-1:0] mc_addr,
  inout  wire  [DWIDTH-1:0] mc_data,
  input  logic              mc_ready,
  output logic              err,
  output logic [2:0]        state_dbg
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     cnt;
  logic [DWIDTH-1:0] wdata_q;
  logic              grant_en;
  logic              grant_valid;
  logic              grant;
  logic              cur_grant;
  logic              take;
  logic              timed_out;
  logic              bus_drive;
  logic              finishing;

  mem_arb_rr u_arb (
    .clk         (clk),
    .reset       (reset),
    .grant_en    (grant_en),
    .if_req      (if_req),
    .d_req       (d_req),
    .grant_valid (grant_valid),
    .grant       (grant),
    .last_grant  (cur_grant)
  );

  assign grant_en  = (state == ST_IDLE) && mc_ready;
  assign take      = grant_en && grant_valid;
  assign timed_out = (cnt == CW'(TIMEOUT - 1));
  assign state_dbg = state;

  // Controller data bus: only write data, only while the request is live.
  assign mc_data   = bus_drive ? wdata_q : {DWIDTH{1'bz}};

  // Next-state and per-state outputs.
  always_comb begin
    state_nx  = state;
    mc_valid  = 1'b0;
    bus_drive = 1'b0;
    finishing = 1'b0;
    err       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (take) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        mc_valid  = 1'b1;
        bus_drive = (mc_rw == RW_WRITE);
        if (!mc_ready)      state_nx = ST_WAIT;
        else if (timed_out) state_nx = ST_ERR;
      end
      ST_WAIT: begin
        mc_valid  = 1'b1;
        bus_drive = (mc_rw == RW_WRITE);
        if (mc_ready)       state_nx = ST_DONE;
        else if (timed_out) state_nx = ST_ERR;
      end
      ST_DONE: begin
        finishing = 1'b1;
        state_nx  = ST_GAP;
      end
      ST_ERR: begin
        finishing = 1'b1;
        err       = 1'b1;
        state_nx  = ST_GAP;
      end
      ST_GAP: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    if_ack = finishing && (cur_grant == GRANT_FETCH);
    d_ack  = finishing && (cur_grant == GRANT_DATA);
  end

  // State, phase counter, latched request fields and read-data capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mc_rw    <= RW_READ;
      mc_addr  <= '0;
      wdata_q  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      state <= state_nx;
      // Counter restarts on every state change, so it measures time in phase.
      if (state_nx != state) begin
        cnt <= '0;
      end else if (state == ST_ISSUE || state == ST_WAIT) begin
        cnt <= cnt + CW'(1);
      end
      if (take) begin
        if (grant == GRANT_FETCH) begin
          mc_addr <= if_addr;
          mc_rw   <= RW_READ;
        end else begin
          mc_addr <= d_addr;
          mc_rw   <= d_rw;
        end
        wdata_q <= d_wdata;
      end
      if (state == ST_WAIT && mc_ready && mc_rw == RW_READ) begin
        if (cur_grant == GRANT_FETCH) if_rdata <= mc_data;
        else                          d_rdata  <= mc_data;
      end
    end
  end

endmodule
